decode_stage_pipe: RTL and testbench

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_stage_pipe.sv | 190 +++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// Decode stage: field decode, scalar/vector register files, pending-write scoreboard, one-deep
// output register. Define DECODE_BYPASS_EN to forward same-cycle writeback data to sources.
module decode_stage_pipe #(
  parameter int unsigned INSTR_W  = 20,
  parameter int unsigned SCALAR_W = 21,
  parameter int unsigned LANES    = 8,
  parameter int unsigned LANE_W   = 24,
  parameter int unsigned NREG     = 16,
  localparam int unsigned VW      = LANES * LANE_W,
  localparam int unsigned RA      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SCALAR_W-1:0] immALU,
  output logic [4:0]          exec,
  output logic [3:0]          mem,
  output logic [1:0]          wb,
  output logic [RA-1:0]       dest,
  output logic                destType_out,
  output logic [SCALAR_W-1:0] r1e,
  output logic [SCALAR_W-1:0] r2e,
  output logic [VW-1:0]       r1v,
  output logic [VW-1:0]       r2v,
  input  logic                wb_en,
  input  logic                wb_type,
  input  logic [RA-1:0]       wb_addr,
  input  logic [SCALAR_W-1:0] wb_sdata,
  input  logic [VW-1:0]       wb_vdata
);

  logic          dtype, s2type, imm;
  logic [3:0]    op;
  logic [RA-1:0] dst, src1, src2;
  logic          unused_instr_bit;

  assign dtype            = instr[19];
  assign s2type           = instr[18];
  assign op               = instr[17:14];
  assign imm              = instr[13];
  assign dst              = instr[9 +: RA];
  assign src1             = instr[5 +: RA];
  assign src2             = instr[1 +: RA];
  assign unused_instr_bit = instr[0];

  logic [SCALAR_W-1:0] immalu_d;
  logic [4:0]          exec_d;
  logic [3:0]          mem_d;
  logic [1:0]          wb_d;

  assign immalu_d = imm ? {{(SCALAR_W-5){instr[4]}}, instr[4:0]} : '0;
  assign exec_d   = {imm, op};
  assign mem_d    = {op == 4'hE, op == 4'hF, dtype, s2type};
  assign wb_d     = {op != 4'hF, dtype};

  logic [SCALAR_W-1:0] sfile_q [NREG];
  logic [VW-1:0]       vfile_q [NREG];
  logic [NREG-1:0]     pend_s_q, pend_s_d, pend_v_q, pend_v_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        sfile_q[i] <= '0;
        vfile_q[i] <= '0;
      end
    end else if (wb_en) begin
      if (wb_type) vfile_q[wb_addr] <= wb_vdata;
      else         sfile_q[wb_addr] <= wb_sdata;
    end
  end

  logic                byp1, byp2;
  logic [SCALAR_W-1:0] s1_s, s2_s;
  logic [VW-1:0]       s1_v, s2_v;
  logic [SCALAR_W-1:0] r1e_d, r2e_d;
  logic [VW-1:0]       r1v_d, r2v_d;
  logic                haz1, haz2, hazw, hazard, accept;

`ifdef DECODE_BYPASS_EN
  assign byp1 = wb_en && (wb_type == dtype) && (wb_addr == src1);
  assign byp2 = wb_en && (wb_type == s2type) && (wb_addr == src2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    s1_s = byp1 ? wb_sdata : sfile_q[src1];
    s1_v = byp1 ? wb_vdata : vfile_q[src1];
    s2_s = byp2 ? wb_sdata : sfile_q[src2];
    s2_v = byp2 ? wb_vdata : vfile_q[src2];
    r1e_d = dtype ? '0 : s1_s;
    r1v_d = dtype ? s1_v : '0;
    r2e_d = '0;
    r2v_d = '0;
    if (!imm) begin
      if (s2type) r2v_d = s2_v;
      else        r2e_d = s2_s;
    end
  end

  // A source being written back this cycle is satisfied only when forwarding is built in.
  assign haz1   = (dtype ? pend_v_q[src1] : pend_s_q[src1]) & ~byp1;
  assign haz2   = ~imm & (s2type ? pend_v_q[src2] : pend_s_q[src2]) & ~byp2;
  assign hazw   = wb_d[1] & (dtype ? pend_v_q[dst] : pend_s_q[dst]);
  assign hazard = haz1 | haz2 | hazw;

  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  // Clear first so a same-cycle set on the same bit wins.
  always_comb begin
    pend_s_d = pend_s_q;
    pend_v_d = pend_v_q;
    if (wb_en) begin
      if (wb_type) pend_v_d[wb_addr] = 1'b0;
      else         pend_s_d[wb_addr] = 1'b0;
    end
    if (accept && wb_d[1]) begin
      if (dtype) pend_v_d[dst] = 1'b1;
      else       pend_s_d[dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s_q <= '0;
      pend_v_q <= '0;
    end else begin
      pend_s_q <= pend_s_d;
      pend_v_q <= pend_v_d;
    end
  end

  logic                out_valid_q;
  logic [SCALAR_W-1:0] immalu_q, r1e_q, r2e_q;
  logic [4:0]          exec_q;
  logic [3:0]          mem_q;
  logic [1:0]          wb_q;
  logic [RA-1:0]       dest_q;
  logic                dtype_q;
  logic [VW-1:0]       r1v_q, r2v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      immalu_q    <= '0;
      exec_q      <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      dest_q      <= '0;
      dtype_q     <= 1'b0;
      r1e_q       <= '0;
      r2e_q       <= '0;
      r1v_q       <= '0;
      r2v_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      immalu_q    <= immalu_d;
      exec_q      <= exec_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      dest_q      <= dst;
      dtype_q     <= dtype;
      r1e_q       <= r1e_d;
      r2e_q       <= r2e_d;
      r1v_q       <= r1v_d;
      r2v_q       <= r2v_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign immALU       = immalu_q;
  assign exec         = exec_q;
  assign mem          = mem_q;
  assign wb           = wb_q;
  assign dest         = dest_q;
  assign destType_out = dtype_q;
  assign r1e          = r1e_q;
  assign r2e          = r2e_q;
  assign r1v          = r1v_q;
  assign r2v          = r2v_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios then randomized traffic, all
// compared against a behavioural model of the register files, scoreboard and output register.
module tb_decode_stage_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [19:0]  instr = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [20:0]  immALU;
  logic [4:0]   exec;
  logic [3:0]   mem;
  logic [1:0]   wb;
  logic [3:0]   dest;
  logic         destType_out;
  logic [20:0]  r1e, r2e;
  logic [191:0] r1v, r2v;
  logic         wb_en = 1'b0;
  logic         wb_type = 1'b0;
  logic [3:0]   wb_addr = '0;
  logic [20:0]  wb_sdata = '0;
  logic [191:0] wb_vdata = '0;

  decode_stage_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .immALU       (immALU),
    .exec         (exec),
    .mem          (mem),
    .wb           (wb),
    .dest         (dest),
    .destType_out (destType_out),
    .r1e          (r1e),
    .r2e          (r2e),
    .r1v          (r1v),
    .r2v          (r2v),
    .wb_en        (wb_en),
    .wb_type      (wb_type),
    .wb_addr      (wb_addr),
    .wb_sdata     (wb_sdata),
    .wb_vdata     (wb_vdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [20:0]  m_s [16];
  logic [191:0] m_v [16];
  bit           m_ps [16];
  bit           m_pv [16];
  logic         e_valid;
  logic [20:0]  e_imm, e_r1e, e_r2e;
  logic [4:0]   e_exec;
  logic [3:0]   e_mem, e_dest;
  logic [1:0]   e_wb;
  logic         e_dt;
  logic [191:0] e_r1v, e_r2v;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_s[i] = '0; m_v[i] = '0; m_ps[i] = 0; m_pv[i] = 0;
    end
    e_valid = 0; e_imm = '0; e_r1e = '0; e_r2e = '0; e_exec = '0; e_mem = '0;
    e_dest = '0; e_wb = '0; e_dt = 0; e_r1v = '0; e_r2v = '0;
  endtask

  function automatic bit byp(input logic t, input logic [3:0] r);
`ifdef DECODE_BYPASS_EN
    return wb_en && (wb_type == t) && (wb_addr == r);
`else
    return 0;
`endif
  endfunction

  function automatic bit pend(input logic t, input logic [3:0] r);
    return t ? m_pv[r] : m_ps[r];
  endfunction

  function automatic logic [191:0] rd(input logic t, input logic [3:0] r);
    if (byp(t, r)) return t ? wb_vdata : {171'b0, wb_sdata};
    return t ? m_v[r] : {171'b0, m_s[r]};
  endfunction

  task automatic check_outs();
    check("out_valid", out_valid, e_valid);
    check("immALU", immALU, e_imm);
    check("exec", exec, e_exec);
    check("mem", mem, e_mem);
    check("wb", wb, e_wb);
    check("dest", dest, e_dest);
    check("destType_out", destType_out, e_dt);
    check("r1e", r1e, e_r1e);
    check("r2e", r2e, e_r2e);
    check("r1v", r1v, e_r1v);
    check("r2v", r2v, e_r2v);
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(output logic rdy_seen, output bit acc);
    logic         dt, s2t, im;
    logic [3:0]   op, d, a, b;
    logic [4:0]   lo;
    logic [191:0] t1, t2;
    bit           haz, rdy;
    dt = instr[19]; s2t = instr[18]; op = instr[17:14]; im = instr[13];
    d = instr[12:9]; a = instr[8:5]; b = instr[4:1]; lo = instr[4:0];
    #1;
    haz = (pend(dt, a) && !byp(dt, a)) || (!im && pend(s2t, b) && !byp(s2t, b)) ||
          (op != 4'hF && pend(dt, d));
    rdy = (!e_valid || out_ready) && !haz;
    rdy_seen = in_ready;
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (acc) begin
      t1 = rd(dt, a);
      t2 = rd(s2t, b);
      e_imm  = im ? 21'($signed(lo)) : 21'd0;
      e_exec = {im, op};
      e_mem  = {op == 4'hE, op == 4'hF, dt, s2t};
      e_wb   = {op != 4'hF, dt};
      e_dest = d;
      e_dt   = dt;
      e_r1e  = dt ? 21'd0 : t1[20:0];
      e_r1v  = dt ? t1 : 192'd0;
      e_r2e  = (im || s2t) ? 21'd0 : t2[20:0];
      e_r2v  = (im || !s2t) ? 192'd0 : t2;
      e_valid = 1;
    end else if (out_ready) begin
      e_valid = 0;
    end
    if (wb_en) begin
      if (wb_type) begin m_v[wb_addr] = wb_vdata; m_pv[wb_addr] = 0; end
      else begin m_s[wb_addr] = wb_sdata; m_ps[wb_addr] = 0; end
    end
    if (acc && op != 4'hF) begin
      if (dt) m_pv[d] = 1;
      else    m_ps[d] = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive(input logic v, input logic [19:0] ins, input logic ordy, input logic we,
                       input logic wt, input logic [3:0] wa, input logic [20:0] sd,
                       input logic [191:0] vd);
    in_valid = v; instr = ins; out_ready = ordy;
    wb_en = we; wb_type = wt; wb_addr = wa; wb_sdata = sd; wb_vdata = vd;
  endtask

  logic rs;
  bit   ac;

  initial begin
    model_reset();
    #12;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;

    // MOV s3 <- 5
    drive(1, 20'h06605, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("mov_accept", ac, 1'b1);
    check("mov_exec", exec, 5'h11);
    check("mov_imm", immALU, 21'h000005);
    check("mov_dest", dest, 4'd3);
    check("mov_wb", wb, 2'b10);

    // Reader of s3 stalls until writeback of 0x55
    drive(1, 20'h08860, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("raw_stall", rs, 1'b0);
    drive(1, 20'h08860, 1, 1, 0, 4'd3, 21'h55, 0);
    cycle(rs, ac);
`ifdef DECODE_BYPASS_EN
    check("raw_byp_accept", ac, 1'b1);
`else
    check("raw_nobyp_stall", ac, 1'b0);
    drive(1, 20'h08860, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("raw_late_accept", ac, 1'b1);
`endif
    check("raw_r1e", r1e, 21'h55);

    // Preload v2 = 1, s4 = 7 (s4 also retires the pending write from the reader above)
    drive(0, 0, 1, 1, 1, 4'd2, 0, 192'h1);
    cycle(rs, ac);
    drive(0, 0, 1, 1, 0, 4'd4, 21'h7, 0);
    cycle(rs, ac);
    drive(1, 20'h8CC48, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("vs_r1v", r1v, 192'h1);
    check("vs_r2e", r2e, 21'h7);
    check("vs_r1e", r1e, 21'h0);
    check("vs_r2v", r2v, 192'h0);
    check("vs_dtype", destType_out, 1'b1);

    // Backpressure: hold outputs for 3 cycles, then accept the waiting store
    drive(1, 20'h3E003, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(rs, ac);
      check("bp_stall", rs, 1'b0);
    end
    drive(1, 20'h3E003, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("bp_release", ac, 1'b1);

    // Set beats clear on s5
    drive(1, 20'h06A01, 1, 1, 0, 4'd5, 21'h9, 0);
    cycle(rs, ac);
    drive(1, 20'h090A0, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("set_wins", rs, 1'b0);
    drive(0, 0, 1, 1, 0, 4'd5, 21'h3, 0);
    cycle(rs, ac);

    // Asynchronous reset while holding a vector writer to v7
    drive(1, 20'h86E01, 0, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("v7_accept", ac, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 20'h882E0, 1, 0, 0, 0, 0, 0);
    cycle(rs, ac);
    check("pend_v_cleared", rs, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, 20'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 1'($urandom), 4'($urandom), 21'($urandom),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      cycle(rs, ac);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
